alu_rs: RTL and testbench

Reservation station and issue scheduler for the ALU execute stage in the Tomasulo core. Buffers up to `RS_SIZE` dispatched ALU/branch micro-ops, tracks operand readiness by snooping the ALU and LSB result broadcasts, selects one ready entry per cycle and drives it into the combinational `ex` unit through registered outputs. It sits between the decoder/dispatch stage and `ex`; the ROB consumes `ex` results together with `ex_valid`.

---
 rtl/alu_rs_if.sv | 55 +++++
 rtl/alu_rs.sv | 202 ++++++++++++++++++++
 tb/tb_alu_rs.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_if.sv
// Dispatch, result-broadcast and execute-issue signals of the ALU reservation station.
// master = dispatcher/CDB side, slave = reservation station.
interface alu_rs_if #(
    parameter int unsigned OP_W   = 5,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              issue_valid;
    logic [OP_W-1:0]   issue_op;
    logic              issue_q1_busy;
    logic              issue_q2_busy;
    logic [TAG_W-1:0]  issue_q1;
    logic [TAG_W-1:0]  issue_q2;
    logic [DATA_W-1:0] issue_v1;
    logic [DATA_W-1:0] issue_v2;
    logic [IMM_W-1:0]  issue_imm;
    logic [ADDR_W-1:0] issue_pc;
    logic [TAG_W-1:0]  issue_tag;
    logic              full_out;

    logic              alu_cdb_valid;
    logic [TAG_W-1:0]  alu_cdb_tag;
    logic [DATA_W-1:0] alu_cdb_data;
    logic              lsb_cdb_valid;
    logic [TAG_W-1:0]  lsb_cdb_tag;
    logic [DATA_W-1:0] lsb_cdb_data;

    logic              ex_valid;
    logic [OP_W-1:0]   op_type_ex;
    logic [DATA_W-1:0] rs1_data_ex;
    logic [DATA_W-1:0] rs2_data_ex;
    logic [IMM_W-1:0]  imm_ex;
    logic [ADDR_W-1:0] pc_ex;
    logic [TAG_W-1:0]  tag_in_rob;

    modport master (
        output issue_valid, issue_op, issue_q1_busy, issue_q2_busy, issue_q1, issue_q2,
        output issue_v1, issue_v2, issue_imm, issue_pc, issue_tag,
        output alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
        output lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data,
        input  full_out, ex_valid, op_type_ex, rs1_data_ex, rs2_data_ex, imm_ex, pc_ex,
        input  tag_in_rob
    );

    modport slave (
        input  issue_valid, issue_op, issue_q1_busy, issue_q2_busy, issue_q1, issue_q2,
        input  issue_v1, issue_v2, issue_imm, issue_pc, issue_tag,
        input  alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
        input  lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data,
        output full_out, ex_valid, op_type_ex, rs1_data_ex, rs2_data_ex, imm_ex, pc_ex,
        output tag_in_rob
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, snoops ALU/LSB broadcasts, issues one op/cycle.
// Define ALU_RS_AGE_EN for oldest-ready selection; otherwise lowest-index ready entry wins.
module alu_rs #(
    parameter int unsigned RS_SIZE = 16,
    parameter int unsigned IDX_W   = $clog2(RS_SIZE),
    parameter int unsigned OP_W    = 5,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IMM_W   = 32,
    parameter int unsigned ADDR_W  = 32
) (
    input logic     clk_in,
    input logic     rst_in,
    input logic     rdy_in,
    input logic     clear_in,
    alu_rs_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic              q1b;
        logic [TAG_W-1:0]  q1;
        logic [DATA_W-1:0] v1;
        logic              q2b;
        logic [TAG_W-1:0]  q2;
        logic [DATA_W-1:0] v2;
        logic [IMM_W-1:0]  imm;
        logic [ADDR_W-1:0] pc;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    // Returns {still_busy, value}; the ALU broadcast wins when both carry the same tag.
    function automatic logic [DATA_W:0] snoop(input logic b, input logic [TAG_W-1:0] t,
                                              input logic [DATA_W-1:0] v, input cdb_t a,
                                              input cdb_t l);
        if (b && a.valid && a.tag == t) return {1'b0, a.data};
        if (b && l.valid && l.tag == t) return {1'b0, l.data};
        return {b, v};
    endfunction

    entry_t             ent_q [RS_SIZE];
    entry_t             ent_d [RS_SIZE];
    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] ready;
    logic               full;
    logic               sel_valid, free_valid, dispatch;
    logic [IDX_W-1:0]   sel_idx, free_idx;
    cdb_t               alu_cdb, lsb_cdb;

    logic               ex_valid_q;
    logic [OP_W-1:0]    op_ex_q;
    logic [DATA_W-1:0]  rs1_ex_q, rs2_ex_q;
    logic [IMM_W-1:0]   imm_ex_q;
    logic [ADDR_W-1:0]  pc_ex_q;
    logic [TAG_W-1:0]   tag_ex_q;

`ifdef ALU_RS_AGE_EN
    // age = number of live entries dispatched before this one; 0 is the oldest.
    logic [IDX_W-1:0]   age_q [RS_SIZE];
    logic [IDX_W-1:0]   age_d [RS_SIZE];
    logic [IDX_W:0]     live;
`endif

    assign alu_cdb  = {bus.alu_cdb_valid, bus.alu_cdb_tag, bus.alu_cdb_data};
    assign lsb_cdb  = {bus.lsb_cdb_valid, bus.lsb_cdb_tag, bus.lsb_cdb_data};
    assign full     = &busy_q;
    assign dispatch = bus.issue_valid & free_valid;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy_q[i] & ~ent_q[i].q1b & ~ent_q[i].q2b;
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
`ifdef ALU_RS_AGE_EN
            if (ready[i] && (!sel_valid || age_q[i] < age_q[sel_idx])) begin
`else
            if (ready[i] && !sel_valid) begin
`endif
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Dispatch sees registered occupancy only, so a slot freed by select is reused next cycle.
    always_comb begin
        free_valid = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!busy_q[i] && !free_valid) begin
                free_valid = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        ent_d  = ent_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i]) begin
                {ent_d[i].q1b, ent_d[i].v1} =
                    snoop(ent_q[i].q1b, ent_q[i].q1, ent_q[i].v1, alu_cdb, lsb_cdb);
                {ent_d[i].q2b, ent_d[i].v2} =
                    snoop(ent_q[i].q2b, ent_q[i].q2, ent_q[i].v2, alu_cdb, lsb_cdb);
            end
        end
        if (sel_valid) begin
            busy_d[sel_idx] = 1'b0;
        end
        if (dispatch) begin
            busy_d[free_idx]    = 1'b1;
            ent_d[free_idx].op  = bus.issue_op;
            ent_d[free_idx].q1  = bus.issue_q1;
            ent_d[free_idx].q2  = bus.issue_q2;
            ent_d[free_idx].imm = bus.issue_imm;
            ent_d[free_idx].pc  = bus.issue_pc;
            ent_d[free_idx].tag = bus.issue_tag;
            {ent_d[free_idx].q1b, ent_d[free_idx].v1} =
                snoop(bus.issue_q1_busy, bus.issue_q1, bus.issue_v1, alu_cdb, lsb_cdb);
            {ent_d[free_idx].q2b, ent_d[free_idx].v2} =
                snoop(bus.issue_q2_busy, bus.issue_q2, bus.issue_v2, alu_cdb, lsb_cdb);
        end
    end

`ifdef ALU_RS_AGE_EN
    always_comb begin
        live = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            live = live + (IDX_W+1)'(busy_q[i]);
        end
        if (sel_valid) begin
            live = live - (IDX_W+1)'(1);
        end
        age_d = age_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (sel_valid && busy_q[i] && age_q[i] > age_q[sel_idx]) begin
                age_d[i] = age_q[i] - IDX_W'(1);
            end
        end
        if (dispatch) begin
            age_d[free_idx] = live[IDX_W-1:0];
        end
    end
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q     <= '0;
            ex_valid_q <= 1'b0;
            op_ex_q    <= '0;
            rs1_ex_q   <= '0;
            rs2_ex_q   <= '0;
            imm_ex_q   <= '0;
            pc_ex_q    <= '0;
            tag_ex_q   <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
`ifdef ALU_RS_AGE_EN
                age_q[i] <= '0;
`endif
            end
        end else if (clear_in) begin
            busy_q     <= '0;
            ex_valid_q <= 1'b0;
        end else if (rdy_in) begin
            busy_q     <= busy_d;
            ent_q      <= ent_d;
            ex_valid_q <= sel_valid;
`ifdef ALU_RS_AGE_EN
            age_q      <= age_d;
`endif
            if (sel_valid) begin
                op_ex_q  <= ent_q[sel_idx].op;
                rs1_ex_q <= ent_q[sel_idx].v1;
                rs2_ex_q <= ent_q[sel_idx].v2;
                imm_ex_q <= ent_q[sel_idx].imm;
                pc_ex_q  <= ent_q[sel_idx].pc;
                tag_ex_q <= ent_q[sel_idx].tag;
            end
        end
    end

    assign bus.full_out    = full;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.op_type_ex  = op_ex_q;
    assign bus.rs1_data_ex = rs1_ex_q;
    assign bus.rs2_data_ex = rs2_ex_q;
    assign bus.imm_ex      = imm_ex_q;
    assign bus.pc_ex       = pc_ex_q;
    assign bus.tag_in_rob  = tag_ex_q;
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed vector table, corner sequences, random vs. model.
module tb_alu_rs;
    localparam int unsigned RS_SIZE = 16;
    localparam int unsigned OP_W    = 5;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned IMM_W   = 32;
    localparam int unsigned ADDR_W  = 32;
`ifdef ALU_RS_AGE_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, rdy, clr;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_rs_if bus ();

    alu_rs #(.RS_SIZE(RS_SIZE)) dut (
        .clk_in  (clk),
        .rst_in  (rst),
        .rdy_in  (rdy),
        .clear_in(clr),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid   = 1'b0; bus.issue_op  = '0;
        bus.issue_q1_busy = 1'b0; bus.issue_q1  = '0; bus.issue_v1 = '0;
        bus.issue_q2_busy = 1'b0; bus.issue_q2  = '0; bus.issue_v2 = '0;
        bus.issue_imm     = '0;   bus.issue_pc  = '0; bus.issue_tag = '0;
        bus.alu_cdb_valid = 1'b0; bus.alu_cdb_tag = '0; bus.alu_cdb_data = '0;
        bus.lsb_cdb_valid = 1'b0; bus.lsb_cdb_tag = '0; bus.lsb_cdb_data = '0;
    endtask

    task automatic put(input logic [OP_W-1:0] op, input logic q1b, input logic [TAG_W-1:0] q1,
                       input logic [DATA_W-1:0] v1, input logic q2b,
                       input logic [TAG_W-1:0] q2, input logic [DATA_W-1:0] v2,
                       input logic [TAG_W-1:0] tag);
        bus.issue_valid   = 1'b1; bus.issue_op = op;
        bus.issue_q1_busy = q1b;  bus.issue_q1 = q1; bus.issue_v1 = v1;
        bus.issue_q2_busy = q2b;  bus.issue_q2 = q2; bus.issue_v2 = v2;
        bus.issue_imm     = '0;   bus.issue_pc = '0; bus.issue_tag = tag;
    endtask

    task automatic alu_bc(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        bus.alu_cdb_valid = 1'b1; bus.alu_cdb_tag = t; bus.alu_cdb_data = d;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1; clr = 1'b0; rdy = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [OP_W-1:0]   op;
        logic              q1b;
        logic [TAG_W-1:0]  q1;
        logic [DATA_W-1:0] v1;
        logic              q2b;
        logic [TAG_W-1:0]  q2;
        logic [DATA_W-1:0] v2;
        logic [IMM_W-1:0]  imm;
        logic [ADDR_W-1:0] pc;
        logic [TAG_W-1:0]  tag;
        logic              av;
        logic [TAG_W-1:0]  at;
        logic [DATA_W-1:0] ad;
        logic              lv;
        logic [TAG_W-1:0]  lt;
        logic [DATA_W-1:0] ld;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
    } vec_t;

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit                busy;
        logic [OP_W-1:0]   op;
        bit                q1b;
        logic [TAG_W-1:0]  q1;
        logic [DATA_W-1:0] v1;
        bit                q2b;
        logic [TAG_W-1:0]  q2;
        logic [DATA_W-1:0] v2;
        logic [IMM_W-1:0]  imm;
        logic [ADDR_W-1:0] pc;
        logic [TAG_W-1:0]  tag;
        int unsigned       seq;
    } ment_t;

    ment_t             m [RS_SIZE];
    bit                m_exv;
    logic [OP_W-1:0]   m_op;
    logic [DATA_W-1:0] m_rs1, m_rs2;
    logic [IMM_W-1:0]  m_imm;
    logic [ADDR_W-1:0] m_pc;
    logic [TAG_W-1:0]  m_tag;
    int unsigned       m_seq;

    function automatic bit cdb_hit(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
        d = '0;
        if (bus.alu_cdb_valid && bus.alu_cdb_tag == t) begin d = bus.alu_cdb_data; return 1'b1; end
        if (bus.lsb_cdb_valid && bus.lsb_cdb_tag == t) begin d = bus.lsb_cdb_data; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic bit m_full();
        foreach (m[i]) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic model_step();
        ment_t             n [RS_SIZE];
        int                sel = -1;
        int                fr  = -1;
        logic [DATA_W-1:0] d;
        if (rst) begin
            foreach (m[i]) m[i].busy = 1'b0;
            m_exv = 1'b0; m_op = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_pc = '0; m_tag = '0;
            return;
        end
        if (clr) begin
            foreach (m[i]) m[i].busy = 1'b0;
            m_exv = 1'b0;
            return;
        end
        if (!rdy) return;
        n = m;
        foreach (m[i]) begin
            if (m[i].busy && !m[i].q1b && !m[i].q2b &&
                (sel < 0 || (AGE && m[i].seq < m[sel].seq))) sel = i;
        end
        m_exv = (sel >= 0);
        if (sel >= 0) begin
            m_op = m[sel].op; m_rs1 = m[sel].v1; m_rs2 = m[sel].v2;
            m_imm = m[sel].imm; m_pc = m[sel].pc; m_tag = m[sel].tag;
            n[sel].busy = 1'b0;
        end
        foreach (m[i]) begin
            if (m[i].busy && m[i].q1b && cdb_hit(m[i].q1, d)) begin n[i].q1b = 1'b0; n[i].v1 = d; end
            if (m[i].busy && m[i].q2b && cdb_hit(m[i].q2, d)) begin n[i].q2b = 1'b0; n[i].v2 = d; end
            if (!m[i].busy && fr < 0) fr = i;
        end
        if (bus.issue_valid && fr >= 0) begin
            n[fr].busy = 1'b1; n[fr].op = bus.issue_op;
            n[fr].q1b = bus.issue_q1_busy; n[fr].q1 = bus.issue_q1; n[fr].v1 = bus.issue_v1;
            n[fr].q2b = bus.issue_q2_busy; n[fr].q2 = bus.issue_q2; n[fr].v2 = bus.issue_v2;
            n[fr].imm = bus.issue_imm; n[fr].pc = bus.issue_pc; n[fr].tag = bus.issue_tag;
            if (n[fr].q1b && cdb_hit(n[fr].q1, d)) begin n[fr].q1b = 1'b0; n[fr].v1 = d; end
            if (n[fr].q2b && cdb_hit(n[fr].q2, d)) begin n[fr].q2b = 1'b0; n[fr].v2 = d; end
            n[fr].seq = m_seq;
            m_seq++;
        end
        m = n;
    endtask

    initial begin
        vec_t vecs [6];
        logic [TAG_W-1:0] first_tag, second_tag;

        vecs[0] = '{5'd1, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd0, 32'd3, 32'h100, 4'd2,
                    1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd5, 32'd0};
        vecs[1] = '{5'd2, 1'b0, 4'd0, 32'd7, 1'b1, 4'd4, 32'd0, 32'd0, 32'h104, 4'd3,
                    1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'hAB, 32'd7, 32'hAB};
        vecs[2] = '{5'd3, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'h55, 32'hFFF, 32'h108, 4'd5,
                    1'b1, 4'd9, 32'h1234, 1'b0, 4'd0, 32'd0, 32'h1234, 32'h55};
        vecs[3] = '{5'd4, 1'b1, 4'd6, 32'd0, 1'b1, 4'd6, 32'd0, 32'd0, 32'h10C, 4'd6,
                    1'b1, 4'd6, 32'h11, 1'b1, 4'd6, 32'h22, 32'h11, 32'h11};
        vecs[4] = '{5'd5, 1'b1, 4'd3, 32'd0, 1'b1, 4'd2, 32'd0, 32'd7, 32'h110, 4'd7,
                    1'b1, 4'd2, 32'h77, 1'b1, 4'd3, 32'h33, 32'h33, 32'h77};
        vecs[5] = '{5'd6, 1'b0, 4'd5, 32'hFFFFFFFF, 1'b0, 4'd0, 32'h80000000, 32'd0, 32'h114,
                    4'd15, 1'b1, 4'd5, 32'h99, 1'b0, 4'd0, 32'd0, 32'hFFFFFFFF, 32'h80000000};

        do_reset();
        chk("reset ex_valid", 64'(bus.ex_valid), 64'(0));
        chk("reset full_out", 64'(bus.full_out), 64'(0));
        chk("reset rs1", 64'(bus.rs1_data_ex), 64'(0));
        chk("reset rs2", 64'(bus.rs2_data_ex), 64'(0));
        chk("reset imm/pc/tag", 64'({bus.imm_ex, bus.pc_ex}) | 64'(bus.tag_in_rob), 64'(0));
        chk("reset op", 64'(bus.op_type_ex), 64'(0));

        foreach (vecs[k]) begin
            bus.issue_valid   = 1'b1;       bus.issue_op = vecs[k].op;
            bus.issue_q1_busy = vecs[k].q1b; bus.issue_q1 = vecs[k].q1; bus.issue_v1 = vecs[k].v1;
            bus.issue_q2_busy = vecs[k].q2b; bus.issue_q2 = vecs[k].q2; bus.issue_v2 = vecs[k].v2;
            bus.issue_imm = vecs[k].imm; bus.issue_pc = vecs[k].pc; bus.issue_tag = vecs[k].tag;
            bus.alu_cdb_valid = vecs[k].av; bus.alu_cdb_tag = vecs[k].at; bus.alu_cdb_data = vecs[k].ad;
            bus.lsb_cdb_valid = vecs[k].lv; bus.lsb_cdb_tag = vecs[k].lt; bus.lsb_cdb_data = vecs[k].ld;
            cyc(); idle();
            chk($sformatf("vec%0d ex_valid t+1", k), 64'(bus.ex_valid), 64'(0));
            cyc();
            chk($sformatf("vec%0d ex_valid t+2", k), 64'(bus.ex_valid), 64'(1));
            chk($sformatf("vec%0d op", k), 64'(bus.op_type_ex), 64'(vecs[k].op));
            chk($sformatf("vec%0d rs1", k), 64'(bus.rs1_data_ex), 64'(vecs[k].e1));
            chk($sformatf("vec%0d rs2", k), 64'(bus.rs2_data_ex), 64'(vecs[k].e2));
            chk($sformatf("vec%0d imm", k), 64'(bus.imm_ex), 64'(vecs[k].imm));
            chk($sformatf("vec%0d pc", k), 64'(bus.pc_ex), 64'(vecs[k].pc));
            chk($sformatf("vec%0d tag", k), 64'(bus.tag_in_rob), 64'(vecs[k].tag));
            cyc();
            chk($sformatf("vec%0d ex_valid t+3", k), 64'(bus.ex_valid), 64'(0));
            chk($sformatf("vec%0d rs1 hold", k), 64'(bus.rs1_data_ex), 64'(vecs[k].e1));
        end

        // Wakeup by broadcast two cycles after dispatch.
        do_reset();
        put(5'd2, 1'b1, 4'd7, 32'd0, 1'b0, 4'd0, 32'd2, 4'd1);
        cyc(); idle();
        chk("wake t+1 ex_valid", 64'(bus.ex_valid), 64'(0));
        cyc(); alu_bc(4'd7, 32'h10);
        chk("wake t+2 ex_valid", 64'(bus.ex_valid), 64'(0));
        cyc(); idle();
        chk("wake t+3 ex_valid", 64'(bus.ex_valid), 64'(0));
        cyc();
        chk("wake t+4 ex_valid", 64'(bus.ex_valid), 64'(1));
        chk("wake rs1", 64'(bus.rs1_data_ex), 64'(32'h10));
        chk("wake rs2", 64'(bus.rs2_data_ex), 64'(2));

        // Fill to capacity; a 17th dispatch must be dropped.
        do_reset();
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            chk($sformatf("fill%0d full_out", i), 64'(bus.full_out), 64'(0));
            put(5'd1, 1'b1, TAG_W'(i), 32'd0, 1'b0, 4'd0, DATA_W'(i), TAG_W'(i));
            cyc();
        end
        idle();
        chk("full after 16", 64'(bus.full_out), 64'(1));
        put(5'd31, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 4'd9);
        cyc(); idle();
        chk("17th full_out", 64'(bus.full_out), 64'(1));
        cyc();
        chk("17th not issued", 64'(bus.ex_valid), 64'(0));
        alu_bc(4'd3, 32'h30);
        cyc(); idle();
        chk("full wake t+1 ex_valid", 64'(bus.ex_valid), 64'(0));
        cyc();
        chk("full wake ex_valid", 64'(bus.ex_valid), 64'(1));
        chk("full wake tag", 64'(bus.tag_in_rob), 64'(3));
        chk("full wake rs1", 64'(bus.rs1_data_ex), 64'(32'h30));
        chk("full_out after issue", 64'(bus.full_out), 64'(0));
        cyc();
        chk("17th never issued", 64'(bus.ex_valid), 64'(0));

        // Flush with three ready entries and a same-cycle dispatch.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            put(5'd1, 1'b1, 4'd5, 32'd0, 1'b0, 4'd0, 32'd0, TAG_W'(i));
            cyc();
        end
        idle(); alu_bc(4'd5, 32'h5);
        cyc(); idle();
        put(5'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 4'd12);
        clr = 1'b1;
        cyc(); clr = 1'b0; idle();
        chk("clear ex_valid", 64'(bus.ex_valid), 64'(0));
        chk("clear full_out", 64'(bus.full_out), 64'(0));
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("clear quiet%0d", i), 64'(bus.ex_valid), 64'(0));
        end

        // Selection order: A in entry 3, B later in recycled entry 0, both woken together.
        do_reset();
        put(5'd1, 1'b1, 4'd10, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0); cyc();
        put(5'd1, 1'b1, 4'd11, 32'd0, 1'b0, 4'd0, 32'd0, 4'd1); cyc();
        put(5'd1, 1'b1, 4'd11, 32'd0, 1'b0, 4'd0, 32'd0, 4'd2); cyc();
        put(5'd1, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0, 4'd3); cyc();
        idle(); alu_bc(4'd10, 32'd0);
        cyc(); idle();
        cyc();
        chk("age e0 issue", 64'(bus.ex_valid), 64'(1));
        chk("age e0 tag", 64'(bus.tag_in_rob), 64'(0));
        put(5'd1, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0, 4'd8);
        cyc(); idle(); alu_bc(4'd12, 32'h4);
        cyc(); idle();
        first_tag  = AGE ? 4'd3 : 4'd8;
        second_tag = AGE ? 4'd8 : 4'd3;
        cyc();
        chk("order first valid", 64'(bus.ex_valid), 64'(1));
        chk("order first tag", 64'(bus.tag_in_rob), 64'(first_tag));
        cyc();
        chk("order second valid", 64'(bus.ex_valid), 64'(1));
        chk("order second tag", 64'(bus.tag_in_rob), 64'(second_tag));

        // Random traffic against the model; inputs change and outputs are sampled at negedge.
        @(negedge clk);
        idle(); rst = 1'b1; clr = 1'b0; rdy = 1'b1;
        m_seq = 0;
        model_step();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd full_out", 64'(bus.full_out), 64'(m_full()));
            chk("rnd ex_valid", 64'(bus.ex_valid), 64'(m_exv));
            chk("rnd op", 64'(bus.op_type_ex), 64'(m_op));
            chk("rnd rs1", 64'(bus.rs1_data_ex), 64'(m_rs1));
            chk("rnd rs2", 64'(bus.rs2_data_ex), 64'(m_rs2));
            chk("rnd imm", 64'(bus.imm_ex), 64'(m_imm));
            chk("rnd pc", 64'(bus.pc_ex), 64'(m_pc));
            chk("rnd tag", 64'(bus.tag_in_rob), 64'(m_tag));
            rst = ($urandom_range(0, 299) == 0);
            clr = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            bus.issue_valid   = ($urandom_range(0, 9) < 6);
            bus.issue_op      = OP_W'($urandom);
            bus.issue_q1_busy = 1'($urandom_range(0, 1));
            bus.issue_q2_busy = 1'($urandom_range(0, 1));
            bus.issue_q1      = TAG_W'($urandom_range(0, 3));
            bus.issue_q2      = TAG_W'($urandom_range(0, 3));
            bus.issue_v1      = $urandom;
            bus.issue_v2      = $urandom;
            bus.issue_imm     = $urandom;
            bus.issue_pc      = $urandom;
            bus.issue_tag     = TAG_W'($urandom);
            bus.alu_cdb_valid = ($urandom_range(0, 9) < 3);
            bus.alu_cdb_tag   = TAG_W'($urandom_range(0, 3));
            bus.alu_cdb_data  = $urandom;
            bus.lsb_cdb_valid = ($urandom_range(0, 9) < 3);
            bus.lsb_cdb_tag   = TAG_W'($urandom_range(0, 3));
            bus.lsb_cdb_data  = $urandom;
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
